// File: rtl/jpeg2k_axis_pkg.sv
// Shared helpers for the JPEG2000 AXI-Stream width converters.
// Slices of a wide word are numbered from the least-significant end.
package jpeg2k_axis_pkg;

    // Slice 0 occupies bits [DataWidth-1:0] and is emitted first.
    localparam bit AXIS_SLICE_LSB_FIRST = 1'b1;

    function automatic int cnt_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/axis_serializer.sv
// Wide-to-narrow AXI-Stream converter: one Ratio*DataWidth word out as Ratio beats, LSB slice first.
// Optional packet-end sideband is enabled with the AXIS_SER_LAST_EN macro.
module axis_serializer
    import jpeg2k_axis_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int Ratio     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [Ratio*DataWidth-1:0] s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
`ifdef AXIS_SER_LAST_EN
    input  logic                       s_last_i,
    output logic                       m_last_o,
`endif
    input  logic                       m_ready_i,
    output logic                       m_valid_o,
    output logic [DataWidth-1:0]       m_data_o
);

    localparam int            CW       = cnt_width(Ratio);
    localparam logic [CW-1:0] LAST_CNT = CW'(Ratio - 1);

    logic [Ratio*DataWidth-1:0] word_q, word_d;
    logic                       valid_q, valid_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       final_beat;
    logic                       in_xfer;
    logic                       out_xfer;

    assign final_beat = (cnt_q == LAST_CNT);
    // A new word may only land as the final beat of the current one leaves.
    assign s_ready_o  = !valid_q | (m_ready_i & final_beat);
    assign m_valid_o  = valid_q;
    assign in_xfer    = s_valid_i & s_ready_o;
    assign out_xfer   = valid_q & m_ready_i;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (out_xfer) begin
            if (!final_beat) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end
        if (in_xfer) begin
            word_d  = s_data_i;
            valid_d = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        m_data_o = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (cnt_q == CW'(k)) m_data_o = word_q[k*DataWidth +: DataWidth];
        end
    end

`ifdef AXIS_SER_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (in_xfer) last_d = s_last_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= 1'b0;
        else       last_q <= last_d;
    end

    assign m_last_o = last_q & final_beat;
`endif

endmodule

// File: tb/tb_axis_serializer.sv
// Directed bench for axis_serializer (Ratio=4 and Ratio=1 instances) with a beat scoreboard.
module tb_axis_serializer;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] a_s_data  = '0;
    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic        a_m_ready = 1'b0;
    logic        a_m_valid;
    logic [15:0] a_m_data;
`ifdef AXIS_SER_LAST_EN
    logic        a_s_last  = 1'b0;
    logic        a_m_last;
`endif

    logic [15:0] b_s_data  = '0;
    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic        b_m_ready = 1'b0;
    logic        b_m_valid;
    logic [15:0] b_m_data;

    int errors = 0;
    int checks = 0;

    beat_t       qa[$];
    logic [15:0] qb[$];
    beat_t       ea;
    logic [15:0] eb;

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] W2 = 64'hA0A3_A0A2_A0A1_A0A0;
    localparam logic [63:0] W3 = 64'hB0B3_B0B2_B0B1_B0B0;
    localparam logic [63:0] W4 = 64'h8888_7777_6666_5555;
    localparam logic [63:0] W5 = 64'hDDDD_CCCC_BBBB_AAAA;

    always #5 clk = ~clk;

    axis_serializer #(.DataWidth(16), .Ratio(4)) dut_a (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_data_i  (a_s_data),
        .s_valid_i (a_s_valid),
        .s_ready_o (a_s_ready),
`ifdef AXIS_SER_LAST_EN
        .s_last_i  (a_s_last),
        .m_last_o  (a_m_last),
`endif
        .m_ready_i (a_m_ready),
        .m_valid_o (a_m_valid),
        .m_data_o  (a_m_data)
    );

`ifdef AXIS_SER_LAST_EN
    logic b_s_last = 1'b0;
    logic b_m_last;
`endif

    axis_serializer #(.DataWidth(16), .Ratio(1)) dut_b (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_data_i  (b_s_data),
        .s_valid_i (b_s_valid),
        .s_ready_o (b_s_ready),
`ifdef AXIS_SER_LAST_EN
        .s_last_i  (b_s_last),
        .m_last_o  (b_m_last),
`endif
        .m_ready_i (b_m_ready),
        .m_valid_o (b_m_valid),
        .m_data_o  (b_m_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: outputs are popped before this cycle's accepted input is pushed.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_m_valid && a_m_ready) begin
                check("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    check("a_beat_data", 64'(a_m_data), 64'(ea.data));
`ifdef AXIS_SER_LAST_EN
                    check("a_beat_last", 64'(a_m_last), 64'(ea.last));
`endif
                end
            end
            if (a_s_valid && a_s_ready) begin
                for (int k = 0; k < 4; k++) begin
                    ea.data = a_s_data[k*16 +: 16];
`ifdef AXIS_SER_LAST_EN
                    ea.last = (k == 3) && a_s_last;
`else
                    ea.last = 1'b0;
`endif
                    qa.push_back(ea);
                end
            end
            if (b_m_valid && b_m_ready) begin
                check("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    check("b_beat_data", 64'(b_m_data), 64'(eb));
                end
            end
            if (b_s_valid && b_s_ready) qb.push_back(b_s_data);
        end
    end

    initial begin
        #3;
        check("rst_a_m_valid", 64'(a_m_valid), 64'd0);
        check("rst_a_m_data", 64'(a_m_data), 64'd0);
        check("rst_b_m_valid", 64'(b_m_valid), 64'd0);
`ifdef AXIS_SER_LAST_EN
        check("rst_a_m_last", 64'(a_m_last), 64'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_a_s_ready", 64'(a_s_ready), 64'd1);

        // Single word, downstream always ready
        a_s_valid = 1'b1;
        a_s_data  = W1;
        a_m_ready = 1'b1;
        tick();
        a_s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("single_m_valid", 64'(a_m_valid), 64'd1);
            check("single_s_ready", 64'(a_s_ready), 64'(i == 3));
            tick();
        end
        check("single_idle", 64'(a_m_valid), 64'd0);

        // Back-to-back words, no bubbles
        a_s_valid = 1'b1;
        a_s_data  = W2;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) a_s_data = W3;
            if (i == 4) a_s_valid = 1'b0;
            check("b2b_m_valid", 64'(a_m_valid), 64'd1);
            check("b2b_s_ready", 64'(a_s_ready), 64'((i % 4) == 3));
            tick();
        end
        check("b2b_idle", 64'(a_m_valid), 64'd0);

        // Backpressure held at beat 2
        a_s_valid = 1'b1;
        a_s_data  = W1;
        tick();
        a_s_valid = 1'b0;
        tick();
        tick();
        a_m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", 64'(a_m_data), 64'h3333);
            check("bp_hold_valid", 64'(a_m_valid), 64'd1);
            check("bp_s_ready", 64'(a_s_ready), 64'd0);
            tick();
        end
        a_m_ready = 1'b1;
        check("bp_resume_b2", 64'(a_m_data), 64'h3333);
        tick();
        check("bp_resume_b3", 64'(a_m_data), 64'h4444);
        tick();
        check("bp_idle", 64'(a_m_valid), 64'd0);

        // Asynchronous reset after beat 1
        a_s_valid = 1'b1;
        a_s_data  = W4;
        tick();
        a_s_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        qa.delete();
        #1;
        check("mid_rst_m_valid", 64'(a_m_valid), 64'd0);
        check("mid_rst_m_data", 64'(a_m_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(a_s_ready), 64'd1);
        check("post_rst_m_valid", 64'(a_m_valid), 64'd0);
        a_s_valid = 1'b1;
        a_s_data  = W5;
        tick();
        a_s_valid = 1'b0;
        check("post_rst_beat0", 64'(a_m_data), 64'hAAAA);
        repeat (4) tick();
        check("post_rst_idle", 64'(a_m_valid), 64'd0);

`ifdef AXIS_SER_LAST_EN
        // Second word flagged as packet end
        a_s_valid = 1'b1;
        a_s_data  = W2;
        a_s_last  = 1'b0;
        tick();
        a_s_data  = W3;
        a_s_last  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                a_s_valid = 1'b0;
                a_s_last  = 1'b0;
            end
            check("last_m_last", 64'(a_m_last), 64'(i == 7));
            tick();
        end
        check("last_idle", 64'(a_m_valid), 64'd0);
`endif

        // Ratio=1: random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            b_s_valid = 1'($urandom_range(0, 1));
            b_s_data  = 16'($urandom);
            b_m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
        tick();
        tick();
        check("r1_drained", 64'(b_m_valid), 64'd0);

        // Ratio=1: one word per cycle at full rate
        b_s_valid = 1'b1;
        b_s_data  = 16'($urandom);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("r1_tput_m_valid", 64'(b_m_valid), 64'd1);
            check("r1_tput_s_ready", 64'(b_s_ready), 64'd1);
            b_s_data = 16'($urandom);
            tick();
        end
        b_s_valid = 1'b0;
        tick();
        tick();
        check("r1_final_idle", 64'(b_m_valid), 64'd0);

        check("a_sb_drained", 64'(qa.size()), 64'd0);
        check("b_sb_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_serializer.md
# axis_serializer

Wide-to-narrow AXI-Stream converter: accepts one word of `Ratio*DataWidth` bits and emits it as `Ratio` consecutive beats of `DataWidth` bits, least-significant slice first. It is the unpacking counterpart of the stream packers. It sits between wide coefficient and codeword producers and narrow downstream consumers, such as the bit-plane coder input and the byte output path. It sustains full throughput: one output beat per cycle with no bubbles between words.

## Interface
- `DataWidth`, 16: width of one output beat.
- `Ratio`, 4: output beats per input word; legal range ≥ 1.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s_data_i`  in  `Ratio*DataWidth`  input word; slice k is `[k*DataWidth +: DataWidth]`.
- `s_valid_i`  in  1  input word valid.
- `s_ready_o`  out  1  block can accept an input word.
- `m_ready_i`  in  1  downstream accepts the current beat.
- `m_valid_o`  out  1  output beat valid.
- `m_data_o`  out  `DataWidth`  current output beat.
- `s_last_i` / `m_last_o`  in / out  1  packet end; present only with `AXIS_SER_LAST_EN` (see Configuration).

## Operation
- **State:**
  - word register `word` (`Ratio*DataWidth` bits)
  - `valid` flag
  - beat counter `cnt`, width `max(1, $clog2(Ratio))`, range 0..Ratio-1.
- **Input transfer:** occurs when `s_valid_i & s_ready_o`. It loads `word <= s_data_i`, `valid <= 1`, `cnt <= 0`.
- **Output transfer:** occurs when `m_valid_o & m_ready_i`.
  - If `cnt != Ratio-1`: `cnt <= cnt+1`.
  - If `cnt == Ratio-1` (final beat) and no simultaneous input transfer: `valid <= 0`, `cnt <= 0`.
  - If `cnt == Ratio-1` with a simultaneous input transfer: the new word loads, `valid` stays 1, `cnt <= 0`.
- **Combinational outputs:**
  - `s_ready_o = !valid | (m_ready_i & cnt == Ratio-1)`.
  - `m_valid_o = valid`.
  - `m_data_o = word[cnt*DataWidth +: DataWidth]`.
- **No input transfer mid-word:** `s_ready_o` is low while beats 0..Ratio-2 of a word are pending.
- **`Ratio == 1`:** the block degenerates to a single-entry register slice. `cnt` is stuck at 0 and every beat is final.
- **Output stability:** while `m_valid_o & !m_ready_i`, `m_data_o` and `m_last_o` hold stable.
- **Input behaviour:** `s_data_i` is ignored when no input transfer occurs.

## Timing
- **Reset values** (asynchronous, immediate on `rst_i` high):
  - `valid = 0`, `cnt = 0`, `word = 0`
  - `m_valid_o = 0`, `m_data_o = 0`, `m_last_o = 0`
  - `s_ready_o = 1` once `rst_i` is low.
- **Latency:** a word accepted at edge N presents beat 0 on `m_*` after edge N, i.e. one cycle.
- **Throughput:** with `m_ready_i` held high and `s_valid_i` held high, the output is continuous, with `Ratio` beats per word and zero idle cycles between words.
- **Combinational paths:** `s_ready_o` depends combinationally on `m_ready_i`. This is the only combinational input-to-output path.
- **Reset mid-word:** the remaining beats are discarded. The first post-reset input word starts at beat 0.

## Configuration
- Macro: `AXIS_SER_LAST_EN`.
- **Defined:**
  - Ports `s_last_i` and `m_last_o` exist.
  - `s_last_i` is registered with the word.
  - `m_last_o = last_q & (cnt == Ratio-1)`, i.e. asserted only on the final beat of a word flagged last.
- **Undefined:** both ports and the `last_q` register are absent. All other behaviour is identical.

## Structure
- **Shared package `jpeg2k_axis_pkg`:**
  - function `cnt_width(ratio)` returning `max(1, $clog2(ratio))`.
  - the slice-index convention (LSB-first), as a documented localparam `AXIS_SLICE_LSB_FIRST = 1`.
- **Sub-modules:** none. Counter, register and mux are small enough for a single module.

## Test plan
- **Single word:** DataWidth=16, Ratio=4, word `0x4444_3333_2222_1111`, m_ready held 1 → beats `0x1111, 0x2222, 0x3333, 0x4444` on 4 consecutive cycles; `s_ready_o` is low for the first 3 of them.
- **Back-to-back words:** s_valid held 1, m_ready held 1 → 8 consecutive output beats, no gap; `s_ready_o` high only on the final-beat cycle of each word.
- **Backpressure:** drop m_ready for 3 cycles at beat 2 → `m_data_o = 0x3333` held stable for all 3 cycles, then `0x3333, 0x4444`; no beat lost or duplicated.
- **Ratio=1:** random words with random m_ready → output sequence equals input sequence; one word per cycle when m_ready is held high.
- **Reset mid-word:** assert rst_i asynchronously after beat 1 → `m_valid_o` falls immediately; the next word starts at its slice 0.
- **`AXIS_SER_LAST_EN`:** two words, second with s_last_i=1 → `m_last_o` is high only on beat 3 of the second word (the 8th beat).
